// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and pipeline control outputs between the datapath and pipe_stall_ctrl.
// The master side is the datapath; the slave side is the stall controller.
interface pipe_stall_ctrl_if;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_use_rt;
    logic       id_is_md;
    logic       id_reads_hilo;
    logic [4:0] idex_rt;
    logic       idex_memread;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       dmem_ready;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_write;
    logic       memwb_bubble;
    logic       md_start;
    logic       md_busy;
    logic       mem_err;

    modport master (
        output ifid_rs, ifid_rt, ifid_use_rt, id_is_md, id_reads_hilo,
               idex_rt, idex_memread, ex_branch_taken, mem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, md_start, md_busy, mem_err
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_use_rt, id_is_md, id_reads_hilo,
               idex_rt, idex_memread, ex_branch_taken, mem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, md_start, md_busy, mem_err
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: post-reset hold, dmem wait,
// branch flush, mult/div busy and load-use, driving all pipeline register controls.
module pipe_stall_ctrl #(
    parameter int MD_LAT   = 4,
    parameter int MEM_TMO  = 16,
    parameter int RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int MD_W   = $clog2(MD_LAT + 1);
    localparam int WAIT_W = $clog2(MEM_TMO + 1);

    typedef enum logic [1:0] {HOLD, RUN, MEM_WAIT} state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [MD_W-1:0]     md_cnt_q, md_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;

    logic freeze, loadUse, mdHazard, idStall, mdBusy;
    logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble;
    logic exmemWrite, memwbBubble, mdStart;

    assign mdBusy   = (md_cnt_q != '0);
    assign freeze   = bus.mem_req & ~bus.dmem_ready;
    assign loadUse  = bus.idex_memread & (bus.idex_rt != 5'd0) &
                      ((bus.idex_rt == bus.ifid_rs) |
                       (bus.ifid_use_rt & (bus.idex_rt == bus.ifid_rt)));
    assign mdHazard = mdBusy & (bus.id_is_md | bus.id_reads_hilo);
    assign idStall  = loadUse | mdHazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= HOLD_W'(RST_HOLD);
            md_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            md_cnt_q   <= md_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // A released MEM_WAIT cycle falls through to the RUN decode in the same cycle.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        md_cnt_d    = mdBusy ? md_cnt_q - MD_W'(1) : md_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q | (wait_cnt_q == WAIT_W'(MEM_TMO));

        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexWrite   = 1'b1;
        idexBubble  = 1'b0;
        exmemWrite  = 1'b1;
        memwbBubble = 1'b0;
        mdStart     = 1'b0;

        if (state_q == HOLD) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            idexBubble  = 1'b1;
            exmemWrite  = 1'b0;
            memwbBubble = 1'b1;
            hold_cnt_d  = hold_cnt_q - HOLD_W'(1);
            if (hold_cnt_q <= HOLD_W'(1)) begin
                state_d = RUN;
            end
        end else if (freeze) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbBubble = 1'b1;
            if (state_q == RUN) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WAIT_W'(1);
            end else if (wait_cnt_q != WAIT_W'(MEM_TMO)) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            if (bus.ex_branch_taken) begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end else if (idStall) begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
            end else if (bus.id_is_md) begin
                mdStart  = 1'b1;
                md_cnt_d = MD_W'(MD_LAT);
            end
        end
    end

    assign bus.pc_write     = pcWrite;
    assign bus.ifid_write   = ifidWrite;
    assign bus.ifid_flush   = ifidFlush;
    assign bus.idex_write   = idexWrite;
    assign bus.idex_bubble  = idexBubble;
    assign bus.exmem_write  = exmemWrite;
    assign bus.memwb_bubble = memwbBubble;
    assign bus.md_start     = mdStart;
    assign bus.md_busy      = mdBusy;
    assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; control outputs are packed into one vector
// {pc,ifid_w,flush,idex_w,idex_bub,exmem_w,memwb_bub,md_start,md_busy,mem_err}.
module tb_pipe_stall_ctrl;

    localparam logic [9:0] V_RESET  = 10'b0000101000;
    localparam logic [9:0] V_NORMAL = 10'b1101010000;
    localparam logic [9:0] V_STALL  = 10'b0001110000;
    localparam logic [9:0] V_FREEZE = 10'b0000001000;
    localparam logic [9:0] V_BRANCH = 10'b1111110000;

    logic clk;
    logic reset_n;
    int   checks;
    int   fails;
    logic [9:0] got;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.MD_LAT(4), .MEM_TMO(16), .RST_HOLD(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrlVec();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                bus.idex_bubble, bus.exmem_write, bus.memwb_bubble,
                bus.md_start, bus.md_busy, bus.mem_err};
    endfunction

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic setIdle();
        bus.ifid_rs         = 5'd0;
        bus.ifid_rt         = 5'd0;
        bus.ifid_use_rt     = 1'b0;
        bus.id_is_md        = 1'b0;
        bus.id_reads_hilo   = 1'b0;
        bus.idex_rt         = 5'd0;
        bus.idex_memread    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.dmem_ready      = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        setIdle();
        #13;
        got = ctrlVec(); checks++;
        if (got !== V_RESET) begin
            $display("[TB] FAIL reset_state: got %b want %b", got, V_RESET); fails++;
        end
        stepCycle();
        reset_n = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_RESET) begin
            $display("[TB] FAIL hold_cycle1: got %b want %b", got, V_RESET); fails++;
        end
        stepCycle(); #1;
        got = ctrlVec(); checks++;
        if (got !== V_RESET) begin
            $display("[TB] FAIL hold_cycle2: got %b want %b", got, V_RESET); fails++;
        end
        stepCycle(); #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL hold_release: got %b want %b", got, V_NORMAL); fails++;
        end
    endtask

    task automatic test_load_use();
        stepCycle();
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_STALL) begin
            $display("[TB] FAIL load_use_rs: got %b want %b", got, V_STALL); fails++;
        end
        stepCycle();
        setIdle();
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL load_use_after: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
        bus.ifid_rt = 5'd0; bus.ifid_use_rt = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL load_use_r0: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        bus.idex_rt = 5'd9; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd9; bus.ifid_use_rt = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_STALL) begin
            $display("[TB] FAIL load_use_rt: got %b want %b", got, V_STALL); fails++;
        end
        stepCycle();
        bus.ifid_use_rt = 1'b0;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL load_use_rt_unused: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        setIdle();
    endtask

    task automatic test_md();
        stepCycle();
        bus.id_is_md = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== 10'b1101010100) begin
            $display("[TB] FAIL md_issue: got %b want %b", got, 10'b1101010100); fails++;
        end
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            bus.id_is_md = 1'b0; bus.id_reads_hilo = 1'b1;
            #1;
            got = ctrlVec(); checks++;
            if (got !== 10'b0001110010) begin
                $display("[TB] FAIL md_hilo_stall%0d: got %b want %b", i, got, 10'b0001110010); fails++;
            end
        end
        stepCycle(); #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL md_done: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        setIdle();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
            #1;
            got = ctrlVec(); checks++;
            if (got !== V_FREEZE) begin
                $display("[TB] FAIL mem_freeze%0d: got %b want %b", i, got, V_FREEZE); fails++;
            end
        end
        stepCycle();
        bus.dmem_ready = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL mem_release: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        setIdle();
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL mem_no_err: got %b want %b", got, V_NORMAL); fails++;
        end
    endtask

    task automatic test_branch();
        stepCycle();
        bus.ex_branch_taken = 1'b1; bus.idex_memread = 1'b1;
        bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8; bus.id_is_md = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_BRANCH) begin
            $display("[TB] FAIL branch_flush: got %b want %b", got, V_BRANCH); fails++;
        end
        stepCycle();
        bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_FREEZE) begin
            $display("[TB] FAIL branch_vs_freeze: got %b want %b", got, V_FREEZE); fails++;
        end
        stepCycle();
        bus.dmem_ready = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_BRANCH) begin
            $display("[TB] FAIL branch_after_wait: got %b want %b", got, V_BRANCH); fails++;
        end
        stepCycle();
        setIdle();
    endtask

    task automatic test_mem_timeout();
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
            #1;
            got = ctrlVec(); checks++;
            if (got !== V_FREEZE) begin
                $display("[TB] FAIL tmo_freeze%0d: got %b want %b", i, got, V_FREEZE); fails++;
            end
        end
        stepCycle();
        bus.dmem_ready = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL tmo_release: got %b want %b", got, V_NORMAL); fails++;
        end
        stepCycle();
        setIdle();
        #1;
        got = ctrlVec(); checks++;
        if (got !== 10'b1101010001) begin
            $display("[TB] FAIL tmo_err_set: got %b want %b", got, 10'b1101010001); fails++;
        end
        stepCycle();
        bus.id_is_md = 1'b1;
        #1;
        got = ctrlVec(); checks++;
        if (got !== 10'b1101010101) begin
            $display("[TB] FAIL tmo_err_sticky: got %b want %b", got, 10'b1101010101); fails++;
        end
        stepCycle();
        bus.id_is_md = 1'b0; bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
        #1;
        got = ctrlVec(); checks++;
        if (got !== 10'b0000001011) begin
            $display("[TB] FAIL busy_wait_err: got %b want %b", got, 10'b0000001011); fails++;
        end
        reset_n = 1'b0;
        #1;
        got = ctrlVec(); checks++;
        if (got !== V_RESET) begin
            $display("[TB] FAIL mid_reset: got %b want %b", got, V_RESET); fails++;
        end
        setIdle();
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        stepCycle(); #1;
        got = ctrlVec(); checks++;
        if (got !== V_NORMAL) begin
            $display("[TB] FAIL post_reset_run: got %b want %b", got, V_NORMAL); fails++;
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_load_use();
        test_md();
        test_mem_wait();
        test_branch();
        test_mem_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
